dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the MEM-stage data port: accepts the load/store requests that the pipeline issues (mem_op, address, store data, byte write strobes).
- Services each request from an internal word-addressed RAM, after a programmable number of wait states, and returns a read-data/error response.
- Sits between the core's MEM stage and the data memory. Serves as both the synthesizable data RAM and the bus-timing model for stall testing.

Parameters:
- ADDR_WIDTH, 10, word-address bits of the internal RAM (depth = 2**ADDR_WIDTH words of 32 bits).
- BASE_ADDR, 32'h0000_0000, byte address of RAM word 0; must be aligned to the RAM size.
- WAIT_STATES, 1, extra cycles between acceptance and response (0..15).

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_op  in  2  mem_op_e: 00 NONE, 01 LOAD, 10 STORE, 11 reserved.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (u32_t).
- req_wrstb  in  4  wrstb_t byte-lane write strobes; bit i selects bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  access fault flag.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; req_ready=0 during reset; rsp_valid=0, rsp_rdata=0, rsp_err=0; wait counter=0.
  - RAM contents are not cleared.
  - Reset during WAIT discards the latched request, including any store not yet committed. Reset during RESP drops the response.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch op/addr/wdata/wrstb.
    - If WAIT_STATES=0, go to RESP; otherwise load counter=WAIT_STATES-1 and go to WAIT.
  - WAIT: req_ready=0. Decrement the counter each cycle. When counter==0, perform the access and go to RESP.
  - RESP: req_ready=0; rsp_valid=1 with stable rdata/err. On rsp_ready, go to IDLE.
  - No new request is accepted in the same cycle the response is consumed; it is accepted in the next IDLE cycle.
- Latency:
  - Request accepted at edge N gives rsp_valid=1 from edge N+1+WAIT_STATES.
  - Minimum request-to-request throughput is WAIT_STATES+3 cycles with rsp_ready held high.
- Access and commit rules:
  - The access is performed exactly once, on the edge entering RESP. Store bytes are committed there, and load data is captured there.
  - Word index = (addr-BASE_ADDR)[ADDR_WIDTH+1:2].
  - LOAD returns the full 32-bit word; the requester extracts bytes.
  - STORE writes only strobed lanes. wrstb=4'b0000 is a legal no-op store (err=0).
  - Loads following a store to the same word observe the new data.
- Error (rsp_err=1, rsp_rdata=0, no RAM write) when any of these hold:
  - addr[1:0]!=0;
  - addr outside [BASE_ADDR, BASE_ADDR+4*2**ADDR_WIDTH);
  - op=NONE or 11.
  Address wrap is not performed; out-of-range is always an error.
- Inputs are sampled only at acceptance; changes to req_* while in WAIT/RESP have no effect.
- Response outputs are registered and hold their value while rsp_valid=1 and rsp_ready=0. rsp_rdata/rsp_err are cleared to 0 on the edge leaving RESP.

Test Plan:
- Reset then idle, WAIT_STATES=1: hold rst_n=0 two cycles.
  -> req_ready=0, rsp_valid=0 during reset; req_ready=1 the cycle after release.
- STORE 0x0000_0010, wdata 0xDEADBEEF, wrstb 4'b1111; then LOAD 0x10, rsp_ready=1, WAIT_STATES=1.
  -> each rsp_valid asserts 2 edges after acceptance; store rsp_rdata=0, err=0; load rsp_rdata=0xDEADBEEF.
- Partial store 0x10, wdata 0x0000_00AA, wrstb 4'b0001, then LOAD 0x10.
  -> rsp_rdata=0xDEADBEAA. A later store with wrstb 4'b0000 leaves the word 0xDEADBEAA.
- Faults:
  - LOAD 0x0000_0012 -> err=1, rdata=0.
  - LOAD 0x0000_1000 (ADDR_WIDTH=10) -> err=1.
  - op=NONE -> err=1.
  - STORE 0x1000 followed by a LOAD of word 0 -> word 0 unchanged.
- Backpressure: LOAD with rsp_ready=0 for 5 cycles while req_valid stays high with new values.
  -> rsp_valid and rsp_rdata stable throughout; req_ready=0; only one access occurs; second request accepted the cycle after the rsp_ready handshake.
- Reset mid-operation: WAIT_STATES=3, STORE 0x20 0x12345678, rst_n=0 on the second WAIT cycle; after release LOAD 0x20.
  -> returns the pre-store value; no spurious rsp_valid after reset.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response handshake between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wrstb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_wrstb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_wrstb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data RAM plus bus-timing model: accepts one load/store, waits WAIT_STATES cycles,
// performs the access once and holds a registered response until it is consumed.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic [32:0] RAM_BYTES = 33'd4 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wrstb_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  logic                  acc_en;
  logic [1:0]            acc_op;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_wrstb;
  logic [31:0]           acc_off;
  logic                  acc_err;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           acc_rdata;

  // With zero wait states the access happens on the accepting edge, so it must
  // see the live request rather than the latched copy.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    acc_en    = 1'b0;
    acc_op    = op_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_wrstb = wrstb_q;
    if (state == ST_IDLE) begin
      acc_op    = bus.req_op;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_wrstb = bus.req_wrstb;
      acc_en    = bus.req_valid && (WAIT_STATES == 0);
    end else if (state == ST_WAIT) begin
      acc_en    = (cnt == 4'd0);
    end
    acc_off   = acc_addr - BASE_ADDR;
    acc_err   = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_off} >= RAM_BYTES) ||
                !((acc_op == OP_LOAD) || (acc_op == OP_STORE));
    acc_idx   = acc_off[ADDR_WIDTH+1:2];
    acc_we    = acc_en && !acc_err && (acc_op == OP_STORE);
    acc_rdata = (!acc_err && (acc_op == OP_LOAD)) ? mem[acc_idx] : 32'h0;
  end

  // NOTE: the RAM array is deliberately left out of reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wrstb[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      op_q        <= 2'b00;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wrstb_q     <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q    <= bus.req_op;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            wrstb_q <= bus.req_wrstb;
            if (WAIT_STATES == 0) begin
              state       <= ST_RESP;
              rsp_rdata_q <= acc_rdata;
              rsp_err_q   <= acc_err;
            end else begin
              cnt   <= WAIT_LOAD;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (acc_en) begin
            state       <= ST_RESP;
            rsp_rdata_q <= acc_rdata;
            rsp_err_q   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          // Valid follows one edge after the access, giving WAIT_STATES+1 edges of latency.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (bus.rsp_ready) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = rst_n && (state == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and random load/store traffic against a word-array model,
// with a WAIT_STATES=1 instance for most traffic and a WAIT_STATES=3 instance for reset-abort.
module tb_dmem_responder;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
  localparam longint     RAM_BYTES = 4 * 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, rst_n_b, sel;
  logic        drv_valid, drv_rsp_ready;
  logic [1:0]  drv_op;
  logic [31:0] drv_addr, drv_wdata;
  logic [3:0]  drv_wrstb;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  assign bus_a.req_valid = drv_valid && !sel;
  assign bus_a.rsp_ready = drv_rsp_ready && !sel;
  assign bus_a.req_op    = drv_op;
  assign bus_a.req_addr  = drv_addr;
  assign bus_a.req_wdata = drv_wdata;
  assign bus_a.req_wrstb = drv_wrstb;
  assign bus_b.req_valid = drv_valid && sel;
  assign bus_b.rsp_ready = drv_rsp_ready && sel;
  assign bus_b.req_op    = drv_op;
  assign bus_b.req_addr  = drv_addr;
  assign bus_b.req_wdata = drv_wdata;
  assign bus_b.req_wrstb = drv_wrstb;

  dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(bus_a.slave)
  );
  dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(bus_b.slave)
  );

  logic        obs_req_ready, obs_rsp_valid, obs_err;
  logic [31:0] obs_rdata;
  assign obs_req_ready = sel ? bus_b.req_ready : bus_a.req_ready;
  assign obs_rsp_valid = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
  assign obs_rdata     = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
  assign obs_err       = sel ? bus_b.rsp_err   : bus_a.rsp_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mdl [2][1024];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: a plain word array per instance, byte-offset range test, lane-wise store merge.
  task automatic model(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wrstb, output logic [31:0] rdata, output logic err);
    longint off;
    int     idx;
    int     d;
    d     = sel ? 1 : 0;
    off   = longint'(addr);
    err   = (addr % 4 != 0) || (off >= RAM_BYTES) || !(op == OP_LOAD || op == OP_STORE);
    rdata = 32'h0;
    if (!err) begin
      idx = int'(off / 4);
      if (op == OP_LOAD) rdata = mdl[d][idx];
      else for (int i = 0; i < 4; i++) if (wrstb[i]) mdl[d][idx][8*i +: 8] = wdata[8*i +: 8];
    end
  endtask

  task automatic junk_req();
    drv_valid = 1'b1;
    drv_op    = 2'($urandom);
    drv_addr  = $urandom;
    drv_wdata = $urandom;
    drv_wrstb = 4'($urandom);
  endtask

  // Called and returns at a negedge; stall = cycles rsp_ready is held low once rsp_valid is seen.
  task automatic txn(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wrstb, input int stall, input bit junk);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          k;
    int          ws;
    ws = sel ? 3 : 1;
    model(op, addr, wdata, wrstb, exp_rdata, exp_err);
    check("req_ready_idle", 32'(obs_req_ready), 32'd1);
    drv_valid     = 1'b1;
    drv_op        = op;
    drv_addr      = addr;
    drv_wdata     = wdata;
    drv_wrstb     = wrstb;
    drv_rsp_ready = (stall == 0);
    @(negedge clk);
    if (junk) junk_req(); else drv_valid = 1'b0;
    k = 0;
    while (!obs_rsp_valid && k < 20) begin
      check("req_ready_busy", 32'(obs_req_ready), 32'd0);
      @(negedge clk);
      k++;
      if (junk) junk_req();
    end
    check("rsp_latency", 32'(k), 32'(ws + 1));
    check("rsp_rdata", obs_rdata, exp_rdata);
    check("rsp_err", 32'(obs_err), 32'(exp_err));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("hold_valid", 32'(obs_rsp_valid), 32'd1);
      check("hold_rdata", obs_rdata, exp_rdata);
      check("hold_err", 32'(obs_err), 32'(exp_err));
      check("hold_req_ready", 32'(obs_req_ready), 32'd0);
      if (junk) junk_req();
    end
    drv_rsp_ready = 1'b1;
    @(negedge clk);
    drv_valid = 1'b0;
    check("post_valid", 32'(obs_rsp_valid), 32'd0);
    check("post_rdata", obs_rdata, 32'h0);
    check("post_err", 32'(obs_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_addr;
    int          r;

    sel = 1'b0; rst_n_a = 1'b0; rst_n_b = 1'b0;
    drv_valid = 1'b0; drv_rsp_ready = 1'b0; drv_op = OP_NONE;
    drv_addr = 32'h0; drv_wdata = 32'h0; drv_wrstb = 4'h0;

    // Reset held for two cycles, then released.
    repeat (2) begin
      @(negedge clk);
      check("rst_req_ready", 32'(obs_req_ready), 32'd0);
      check("rst_rsp_valid", 32'(obs_rsp_valid), 32'd0);
    end
    rst_n_a = 1'b1;
    @(negedge clk);
    check("release_req_ready", 32'(obs_req_ready), 32'd1);

    for (int w = 0; w < 16; w++) txn(OP_STORE, 32'(4 * w), $urandom, 4'hF, 0, 1'b0);

    txn(OP_STORE, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, 1'b0);
    txn(OP_LOAD,  32'h10, 32'h0,         4'b0000, 0, 1'b0);
    txn(OP_STORE, 32'h10, 32'h0000_00AA, 4'b0001, 0, 1'b0);
    txn(OP_LOAD,  32'h10, 32'h0,         4'b0000, 0, 1'b0);
    txn(OP_STORE, 32'h10, 32'hFFFF_FFFF, 4'b0000, 0, 1'b0);
    txn(OP_LOAD,  32'h10, 32'h0,         4'b0000, 0, 1'b0);

    txn(OP_LOAD,  32'h12,   32'h0,         4'h0, 0, 1'b0);
    txn(OP_LOAD,  32'h1000, 32'h0,         4'h0, 0, 1'b0);
    txn(OP_NONE,  32'h10,   32'h0,         4'hF, 0, 1'b0);
    txn(OP_RSVD,  32'h10,   32'h5555_5555, 4'hF, 0, 1'b0);
    txn(OP_STORE, 32'h1000, 32'h1111_1111, 4'hF, 0, 1'b0);
    txn(OP_LOAD,  32'h0,    32'h0,         4'h0, 0, 1'b0);

    // Backpressure with the request lines churning; a following load proves no extra access.
    txn(OP_LOAD,  32'h10, 32'h0,         4'h0, 5, 1'b1);
    txn(OP_STORE, 32'h14, 32'h0BAD_F00D, 4'hF, 5, 1'b1);
    txn(OP_LOAD,  32'h14, 32'h0,         4'h0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      r_op = (r < 4) ? OP_LOAD : (r < 8) ? OP_STORE : (r == 8) ? OP_NONE : OP_RSVD;
      r = $urandom_range(0, 9);
      if (r < 7)       r_addr = 32'(4 * $urandom_range(0, 15));
      else if (r == 7) r_addr = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
      else if (r == 8) r_addr = 32'h1000 + 32'(4 * $urandom_range(0, 255));
      else             r_addr = 32'hFFFF_FFFC;
      txn(r_op, r_addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
          1'($urandom_range(0, 1)));
    end

    // WAIT_STATES=3 instance: reset on the second WAIT cycle must abort the store.
    sel = 1'b1;
    rst_n_b = 1'b1;
    @(negedge clk);
    txn(OP_STORE, 32'h20, 32'hA5A5_5A5A, 4'hF, 0, 1'b0);
    txn(OP_LOAD,  32'h20, 32'h0,         4'h0, 0, 1'b0);
    check("abort_req_ready", 32'(obs_req_ready), 32'd1);
    drv_valid = 1'b1; drv_op = OP_STORE; drv_addr = 32'h20;
    drv_wdata = 32'h1234_5678; drv_wrstb = 4'hF; drv_rsp_ready = 1'b1;
    @(negedge clk);
    drv_valid = 1'b0;
    @(negedge clk);
    rst_n_b = 1'b0;
    @(negedge clk);
    check("abort_rst_valid", 32'(obs_rsp_valid), 32'd0);
    check("abort_rst_ready", 32'(obs_req_ready), 32'd0);
    rst_n_b = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("abort_no_spurious", 32'(obs_rsp_valid), 32'd0);
    end
    txn(OP_LOAD, 32'h20, 32'h0, 4'h0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
